// File: rtl/lampfpu_cmp_arb.sv
// lampfpu_cmp_arb: two-requester round-robin front end for a registered bfloat16 comparator.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   per-requester request handshake (ready only in IDLE)
//   req_op_i                    per-requester op: 00 EQ, 01 LT, 10 LE, 11 illegal
//   req_a_i, req_b_i            per-requester raw operands
//   rsp_valid_o / rsp_ready_i   per-requester response handshake
//   rsp_cmp_o, rsp_inv_o        shared response payload, qualified by rsp_valid_o
//   doEq_o, doLt_o, doLe_o      one-cycle comparator op select (ISSUE only)
//   opA*/opB*, isA*/isB*        comparator operand fields and class flags (ISSUE only)
//   cmp_i, isCmpValid_i,
//   isCmpInvalid_i              registered comparator result
//   busy_o                      FSM not in IDLE
//   inv_cnt_o                   saturating count of invalid responses
module lampfpu_cmp_arb #(
    parameter int FLOAT_DW = 16,
    parameter int E_DW     = 8,
    parameter int F_DW     = 7,
    parameter int CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid_i,
    output logic [1:0]               req_ready_o,
    input  logic [1:0][1:0]          req_op_i,
    input  logic [1:0][FLOAT_DW-1:0] req_a_i,
    input  logic [1:0][FLOAT_DW-1:0] req_b_i,
    output logic [1:0]               rsp_valid_o,
    input  logic [1:0]               rsp_ready_i,
    output logic                     rsp_cmp_o,
    output logic                     rsp_inv_o,
    output logic                     doEq_o,
    output logic                     doLt_o,
    output logic                     doLe_o,
    output logic                     opASign_o,
    output logic [E_DW-1:0]          opAExp_o,
    output logic [F_DW-1:0]          opAFract_o,
    output logic                     opBSign_o,
    output logic [E_DW-1:0]          opBExp_o,
    output logic [F_DW-1:0]          opBFract_o,
    output logic                     isAZer_o,
    output logic                     isASNaN_o,
    output logic                     isAQNaN_o,
    output logic                     isBZer_o,
    output logic                     isBSNaN_o,
    output logic                     isBQNaN_o,
    input  logic                     cmp_i,
    input  logic                     isCmpValid_i,
    input  logic                     isCmpInvalid_i,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         inv_cnt_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [1:0]          op_q, op_d;
    logic [FLOAT_DW-1:0] a_q, a_d, b_q, b_d;
    logic                rsp_cmp_q, rsp_cmp_d;
    logic                rsp_inv_q, rsp_inv_d;
    logic [CNT_W-1:0]    inv_cnt_q, inv_cnt_d;
    logic                sel;
    logic                issue;
    logic [E_DW-1:0]     a_exp, b_exp;
    logic [F_DW-1:0]     a_frac, b_frac;
    logic                a_nan, b_nan;

    // On contention the requester not granted last wins; a lone requester always wins.
    assign sel = (&req_valid_i) ? ~last_q : req_valid_i[1];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_cmp_d   = rsp_cmp_q;
        rsp_inv_d   = rsp_inv_q;
        inv_cnt_d   = inv_cnt_q;
        req_ready_o = 2'b00;
        rsp_valid_o = 2'b00;
        doEq_o      = 1'b0;
        doLt_o      = 1'b0;
        doLe_o      = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so the grant stays low while reset is held.
                if (rst_n && |req_valid_i) begin
                    req_ready_o = sel ? 2'b10 : 2'b01;
                    gnt_d       = sel;
                    op_d        = req_op_i[sel];
                    a_d         = req_a_i[sel];
                    b_d         = req_b_i[sel];
                    // Illegal op skips the comparator and answers invalid directly.
                    if (&req_op_i[sel]) begin
                        rsp_cmp_d = 1'b0;
                        rsp_inv_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                doEq_o  = op_q == 2'b00;
                doLt_o  = op_q == 2'b01;
                doLe_o  = op_q == 2'b10;
                state_d = WAIT;
            end
            WAIT: begin
                if (isCmpValid_i) begin
                    rsp_cmp_d = cmp_i;
                    rsp_inv_d = isCmpInvalid_i;
                    state_d   = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = gnt_q ? 2'b10 : 2'b01;
                if (rsp_ready_i[gnt_q]) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                    if (rsp_inv_q && !(&inv_cnt_q))
                        inv_cnt_d = inv_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            rsp_cmp_q <= 1'b0;
            rsp_inv_q <= 1'b0;
            inv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rsp_cmp_q <= rsp_cmp_d;
            rsp_inv_q <= rsp_inv_d;
            inv_cnt_q <= inv_cnt_d;
        end
    end

    assign a_exp  = a_q[FLOAT_DW-2 -: E_DW];
    assign b_exp  = b_q[FLOAT_DW-2 -: E_DW];
    assign a_frac = a_q[F_DW-1:0];
    assign b_frac = b_q[F_DW-1:0];
    assign a_nan  = &a_exp && |a_frac;
    assign b_nan  = &b_exp && |b_frac;

    // Operand fields and flags are only presented alongside the do* pulse.
    assign issue      = state_q == ISSUE;
    assign opASign_o  = issue & a_q[FLOAT_DW-1];
    assign opBSign_o  = issue & b_q[FLOAT_DW-1];
    assign opAExp_o   = issue ? a_exp : '0;
    assign opBExp_o   = issue ? b_exp : '0;
    assign opAFract_o = issue ? a_frac : '0;
    assign opBFract_o = issue ? b_frac : '0;
    assign isAZer_o   = issue && a_exp == '0 && a_frac == '0;
    assign isBZer_o   = issue && b_exp == '0 && b_frac == '0;
    assign isAQNaN_o  = issue && a_nan && a_frac[F_DW-1];
    assign isASNaN_o  = issue && a_nan && !a_frac[F_DW-1];
    assign isBQNaN_o  = issue && b_nan && b_frac[F_DW-1];
    assign isBSNaN_o  = issue && b_nan && !b_frac[F_DW-1];

    assign rsp_cmp_o = rsp_cmp_q;
    assign rsp_inv_o = rsp_inv_q;
    assign busy_o    = state_q != IDLE;
    assign inv_cnt_o = inv_cnt_q;

endmodule

// File: tb/tb_lampfpu_cmp_arb.sv
// tb_lampfpu_cmp_arb: directed self-checking bench for lampfpu_cmp_arb with a registered comparator model.
module tb_lampfpu_cmp_arb;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid_i = '0, req_ready_o, rsp_valid_o, rsp_ready_i = '0;
    logic [1:0][1:0] req_op_i = '0;
    logic [1:0][15:0] req_a_i = '0, req_b_i = '0;
    logic            rsp_cmp_o, rsp_inv_o, doEq_o, doLt_o, doLe_o;
    logic            opASign_o, opBSign_o;
    logic [7:0]      opAExp_o, opBExp_o;
    logic [6:0]      opAFract_o, opBFract_o;
    logic            isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o;
    logic            cmp_i, isCmpValid_i, isCmpInvalid_i, busy_o;
    logic [7:0]      inv_cnt_o;
    logic            hold = 1'b0;
    logic            pend;
    logic [1:0]      res = 2'b00;
    logic [55:0]     all_o;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    lampfpu_cmp_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_cmp_o(rsp_cmp_o), .rsp_inv_o(rsp_inv_o),
        .doEq_o(doEq_o), .doLt_o(doLt_o), .doLe_o(doLe_o),
        .opASign_o(opASign_o), .opAExp_o(opAExp_o), .opAFract_o(opAFract_o),
        .opBSign_o(opBSign_o), .opBExp_o(opBExp_o), .opBFract_o(opBFract_o),
        .isAZer_o(isAZer_o), .isASNaN_o(isASNaN_o), .isAQNaN_o(isAQNaN_o),
        .isBZer_o(isBZer_o), .isBSNaN_o(isBSNaN_o), .isBQNaN_o(isBQNaN_o),
        .cmp_i(cmp_i), .isCmpValid_i(isCmpValid_i), .isCmpInvalid_i(isCmpInvalid_i),
        .busy_o(busy_o), .inv_cnt_o(inv_cnt_o)
    );

    assign all_o = {req_ready_o, rsp_valid_o, rsp_cmp_o, rsp_inv_o, doEq_o, doLt_o, doLe_o,
                    opASign_o, opAExp_o, opAFract_o, opBSign_o, opBExp_o, opBFract_o,
                    isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o,
                    busy_o, inv_cnt_o};

    // Signed-magnitude to monotonic key for ordering.
    function automatic logic [15:0] key(input logic [15:0] x);
        key = x[15] ? {1'b0, ~x[14:0]} : {1'b1, x[14:0]};
    endfunction

    // Returns {invalid, result}; EQ is quiet, LT/LE signal on any NaN.
    function automatic logic [1:0] model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic an, bn, as, bs, bz, eq, lt, c, inv;
        an  = &a[14:7] && |a[6:0];
        bn  = &b[14:7] && |b[6:0];
        as  = an && !a[6];
        bs  = bn && !b[6];
        inv = (op == 2'b00) ? (as | bs) : (an | bn);
        bz  = a[14:0] == 15'd0 && b[14:0] == 15'd0;
        eq  = bz || a == b;
        lt  = !bz && key(a) < key(b);
        c   = (an | bn) ? 1'b0 : (op == 2'b00) ? eq : (op == 2'b01) ? lt : (lt | eq);
        model = {inv, c};
    endfunction

    // Registered comparator: result valid the cycle after the do* pulse, optionally stalled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= 1'b0;
        else if (doEq_o | doLt_o | doLe_o) begin
            pend <= 1'b1;
            res  <= model({doLe_o, doLt_o}, {opASign_o, opAExp_o, opAFract_o}, {opBSign_o, opBExp_o, opBFract_o});
        end else if (isCmpValid_i) pend <= 1'b0;
    end
    assign isCmpValid_i = pend && !hold;
    assign {isCmpInvalid_i, cmp_i} = res;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b00;
        hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        req_valid_i = 2'b11;
        #1;
        checks++;
        if (all_o !== 56'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", all_o); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if ({req_ready_o, busy_o} !== 3'b010) begin errors++; $display("FAIL reset_first_grant got %b exp 010", {req_ready_o, busy_o}); end
        req_valid_i = 2'b00;
        tick;
    endtask

    task automatic test_single_eq;
        req_valid_i = 2'b01; req_op_i[0] = 2'b00; req_a_i[0] = 16'h3F80; req_b_i[0] = 16'h3F80; rsp_ready_i = 2'b01;
        #1;
        checks++;
        if ({req_ready_o, busy_o} !== 3'b010) begin errors++; $display("FAIL eq_grant got %b exp 010", {req_ready_o, busy_o}); end
        tick; req_valid_i = 2'b00; #1;
        checks++;
        if ({doEq_o, doLt_o, doLe_o, req_ready_o, busy_o} !== 6'b100001) begin errors++; $display("FAIL eq_issue got %b exp 100001", {doEq_o, doLt_o, doLe_o, req_ready_o, busy_o}); end
        checks++;
        if ({opASign_o, opAExp_o, opAFract_o, opBSign_o, opBExp_o, opBFract_o} !== {16'h3F80, 16'h3F80} ||
            {isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o} !== 6'd0) begin
            errors++; $display("FAIL eq_fields got %h %b exp 3f803f80 000000", {opASign_o, opAExp_o, opAFract_o, opBSign_o, opBExp_o, opBFract_o},
                               {isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o});
        end
        tick; #1;
        checks++;
        if ({rsp_valid_o, doEq_o, doLt_o, doLe_o} !== 5'd0) begin errors++; $display("FAIL eq_wait got %b exp 00000", {rsp_valid_o, doEq_o, doLt_o, doLe_o}); end
        tick; #1;
        checks++;
        if ({rsp_valid_o, rsp_cmp_o, rsp_inv_o} !== 4'b0110) begin errors++; $display("FAIL eq_resp got %b exp 0110", {rsp_valid_o, rsp_cmp_o, rsp_inv_o}); end
        tick; #1;
        checks++;
        if ({rsp_valid_o, busy_o} !== 3'b000) begin errors++; $display("FAIL eq_done got %b exp 000", {rsp_valid_o, busy_o}); end
    endtask

    task automatic test_nan;
        for (int v = 0; v < 2; v++) begin
            req_valid_i = 2'b01;
            req_op_i[0] = v ? 2'b00 : 2'b01;
            req_a_i[0]  = v ? 16'h7FC0 : 16'h7F81;
            req_b_i[0]  = v ? 16'h7FC0 : 16'h3F80;
            rsp_ready_i = 2'b01;
            tick; req_valid_i = 2'b00; #1;
            checks++;
            if ({doEq_o, doLt_o, isASNaN_o, isAQNaN_o, isBSNaN_o, isBQNaN_o} !== (v ? 6'b100101 : 6'b011000)) begin
                errors++; $display("FAIL nan_flags v%0d got %b exp %b", v, {doEq_o, doLt_o, isASNaN_o, isAQNaN_o, isBSNaN_o, isBQNaN_o}, v ? 6'b100101 : 6'b011000);
            end
            tick; tick; #1;
            checks++;
            if ({rsp_valid_o, rsp_cmp_o, rsp_inv_o} !== (v ? 4'b0100 : 4'b0101)) begin
                errors++; $display("FAIL nan_resp v%0d got %b exp %b", v, {rsp_valid_o, rsp_cmp_o, rsp_inv_o}, v ? 4'b0100 : 4'b0101);
            end
            tick; #1;
            checks++;
            if (inv_cnt_o !== 8'd1) begin errors++; $display("FAIL nan_cnt v%0d got %0d exp 1", v, inv_cnt_o); end
        end
    endtask

    task automatic test_illegal;
        req_valid_i = 2'b01; req_op_i[0] = 2'b11; req_a_i[0] = 16'h3F80; req_b_i[0] = 16'h3F80; rsp_ready_i = 2'b00;
        #1;
        checks++;
        if ({req_ready_o, doEq_o, doLt_o, doLe_o} !== 5'b01000) begin errors++; $display("FAIL ill_grant got %b exp 01000", {req_ready_o, doEq_o, doLt_o, doLe_o}); end
        tick; req_valid_i = 2'b00; #1;
        checks++;
        if ({rsp_valid_o, rsp_cmp_o, rsp_inv_o, doEq_o, doLt_o, doLe_o, busy_o} !== 8'b01010001) begin
            errors++; $display("FAIL ill_resp got %b exp 01010001", {rsp_valid_o, rsp_cmp_o, rsp_inv_o, doEq_o, doLt_o, doLe_o, busy_o});
        end
        rsp_ready_i = 2'b01;
        tick; #1;
        checks++;
        if ({inv_cnt_o, busy_o} !== {8'd2, 1'b0}) begin errors++; $display("FAIL ill_cnt got %0d/%b exp 2/0", inv_cnt_o, busy_o); end
    endtask

    task automatic test_contention;
        apply_reset;
        req_valid_i = 2'b11; rsp_ready_i = 2'b11;
        req_op_i[0] = 2'b00; req_a_i[0] = 16'h3F80; req_b_i[0] = 16'h3F80;
        req_op_i[1] = 2'b01; req_a_i[1] = 16'h4000; req_b_i[1] = 16'h3F80;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req_ready_o !== (i[0] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant %0d got %b exp %b", i, req_ready_o, i[0] ? 2'b10 : 2'b01); end
            tick; tick; tick; #1;
            checks++;
            if ({rsp_valid_o, rsp_cmp_o, rsp_inv_o, busy_o} !== {(i[0] ? 2'b10 : 2'b01), ~i[0], 1'b0, 1'b1}) begin
                errors++; $display("FAIL rr_resp %0d got %b exp %b", i, {rsp_valid_o, rsp_cmp_o, rsp_inv_o, busy_o}, {(i[0] ? 2'b10 : 2'b01), ~i[0], 1'b0, 1'b1});
            end
            tick;
        end
        req_valid_i = 2'b00;
    endtask

    task automatic test_backpressure;
        req_valid_i = 2'b11; rsp_ready_i = 2'b10;
        req_op_i[0] = 2'b10; req_a_i[0] = 16'hBF80; req_b_i[0] = 16'h8000;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) begin errors++; $display("FAIL bp_grant got %b exp 01", req_ready_o); end
        tick; #1;
        checks++;
        if ({doLe_o, isBZer_o, isAZer_o, req_ready_o} !== 5'b11000) begin errors++; $display("FAIL bp_issue got %b exp 11000", {doLe_o, isBZer_o, isAZer_o, req_ready_o}); end
        tick; tick;
        for (int k = 0; k < 6; k++) begin
            req_valid_i = k[0] ? 2'b01 : 2'b10;
            if (k == 5) rsp_ready_i = 2'b01;
            #1;
            checks++;
            if ({rsp_valid_o, rsp_cmp_o, rsp_inv_o, req_ready_o} !== 6'b011000) begin
                errors++; $display("FAIL bp_hold %0d got %b exp 011000", k, {rsp_valid_o, rsp_cmp_o, rsp_inv_o, req_ready_o});
            end
            tick;
        end
        req_valid_i = 2'b11;
        #1;
        checks++;
        if ({req_ready_o, busy_o} !== 3'b100) begin errors++; $display("FAIL bp_next_grant got %b exp 100", {req_ready_o, busy_o}); end
        req_valid_i = 2'b00;
        tick;
    endtask

    task automatic test_mid_reset;
        hold = 1'b1;
        req_valid_i = 2'b01; req_op_i[0] = 2'b00; req_a_i[0] = 16'h3F80; req_b_i[0] = 16'h3F80; rsp_ready_i = 2'b01;
        tick; req_valid_i = 2'b00;
        tick; tick; #1;
        checks++;
        if ({busy_o, rsp_valid_o} !== 3'b100) begin errors++; $display("FAIL mr_wait got %b exp 100", {busy_o, rsp_valid_o}); end
        #2 rst_n = 1'b0; req_valid_i = 2'b11;
        #1;
        checks++;
        if (all_o !== 56'd0) begin errors++; $display("FAIL mr_async_outputs got %h exp 0", all_o); end
        hold = 1'b0;
        req_valid_i = 2'b10; req_op_i[1] = 2'b00; req_a_i[1] = 16'h4000; req_b_i[1] = 16'h4000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 2'b10) begin errors++; $display("FAIL mr_grant got %b exp 10", req_ready_o); end
        rsp_ready_i = 2'b10;
        tick; req_valid_i = 2'b00;
        tick; tick; #1;
        checks++;
        if ({rsp_valid_o, rsp_cmp_o, rsp_inv_o} !== 4'b1010) begin errors++; $display("FAIL mr_resp got %b exp 1010", {rsp_valid_o, rsp_cmp_o, rsp_inv_o}); end
        tick;
    endtask

    task automatic test_saturation;
        apply_reset;
        req_valid_i = 2'b01; req_op_i[0] = 2'b11; rsp_ready_i = 2'b01;
        for (int i = 0; i < 260; i++) begin
            tick; tick;
            if (i == 253 || i == 254 || i == 259) begin
                checks++;
                if (inv_cnt_o !== ((i == 253) ? 8'hFE : 8'hFF)) begin
                    errors++; $display("FAIL sat_cnt after %0d got %h exp %h", i + 1, inv_cnt_o, (i == 253) ? 8'hFE : 8'hFF);
                end
            end
        end
        req_valid_i = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_eq;
        test_nan;
        test_illegal;
        test_contention;
        test_backpressure;
        test_mid_reset;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lampfpu_cmp_arb.md
LAMPFPU_CMP_ARB -- requirements
Module: lampfpu_cmp_arb

Interface
REQ-001 The block SHALL use one clock `clk`; reset is asynchronous and active-low, port `rst_n`.
REQ-002 The block SHALL have the following parameters, one per line as name, default, meaning:
- FLOAT_DW, 16, raw bfloat16 operand width.
- E_DW, 8, exponent width.
- F_DW, 7, fraction width.
- CNT_W, 8, invalid-event counter width.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req_valid_i  in  2  per-requester request valid.
- req_ready_o  out  2  per-requester request accepted.
- req_op_i  in  2x2  per-requester op: 00 EQ, 01 LT, 10 LE, 11 illegal.
- req_a_i, req_b_i  in  2xFLOAT_DW  per-requester raw operands.
- rsp_valid_o  out  2  per-requester response valid.
- rsp_ready_i  in  2  per-requester response accepted.
- rsp_cmp_o  out  1  comparison result, shared; qualified by rsp_valid_o.
- rsp_inv_o  out  1  invalid-operation flag, shared; qualified by rsp_valid_o.
- doEq_o, doLt_o, doLe_o  out  1 each  comparator op selects.
- opASign_o, opAExp_o, opAFract_o, opBSign_o, opBExp_o, opBFract_o  out  1/E_DW/F_DW  comparator operand fields.
- isAZer_o, isASNaN_o, isAQNaN_o, isBZer_o, isBSNaN_o, isBQNaN_o  out  1 each  operand class flags.
- cmp_i, isCmpValid_i, isCmpInvalid_i  in  1 each  registered comparator result.
- busy_o  out  1  FSM not in IDLE.
- inv_cnt_o  out  CNT_W  saturating count of invalid responses.

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-005 In IDLE with any req_valid_i set, the block SHALL grant exactly one requester and assert its req_ready_o combinationally in that cycle.
REQ-006 The block SHALL capture the granted requester's op and both operands into registers in the grant cycle, then go to ISSUE.
REQ-007 Arbitration SHALL be round-robin: on contention, the requester that was not last granted wins; a single requester is granted regardless of history.
REQ-008 req_ready_o SHALL be 0 in every state other than IDLE.
REQ-009 In ISSUE, the block SHALL drive exactly one of doEq_o, doLt_o, doLe_o high for one cycle, together with the captured operand fields and class flags, then go to WAIT.
REQ-010 In all states other than ISSUE, doEq_o, doLt_o and doLe_o SHALL be 0.
REQ-011 Operand fields SHALL be split as sign = bit[FLOAT_DW-1], exp = the next E_DW bits, fract = the low F_DW bits.
REQ-012 Class flags SHALL be:
- Zer = (exp==0 && fract==0).
- NaN = (exp all ones && fract!=0).
- QNaN = NaN && fract MSB = 1.
- SNaN = NaN && fract MSB = 0.
REQ-013 In WAIT, the block SHALL remain until isCmpValid_i = 1, then register cmp_i and isCmpInvalid_i into the response register and go to RESP.
REQ-014 An illegal op (11) SHALL bypass the comparator: the block goes from IDLE directly to RESP with rsp_cmp_o = 0 and rsp_inv_o = 1, and drives no do* pulse.
REQ-015 In RESP, rsp_valid_o[g] SHALL be held at 1 for the granted requester g only, with rsp_cmp_o and rsp_inv_o stable.
REQ-016 On rsp_valid_o[g] && rsp_ready_i[g], the block SHALL go to IDLE and record g as last granted.
REQ-017 A new grant SHALL be possible in the IDLE cycle immediately after the RESP handshake.
REQ-018 Legal-op latency SHALL be: accept at cycle T, do* at T+1, comparator output at T+2, rsp_valid_o at T+3 at the earliest.
REQ-019 Illegal-op latency SHALL be rsp_valid_o at T+1.
REQ-020 inv_cnt_o SHALL increment by 1 on each completed response handshake with rsp_inv_o = 1, and saturate at all ones with no wrap.
REQ-021 req_valid_i changing while the block is not in IDLE SHALL have no effect.
REQ-022 rsp_ready_i asserted outside RESP, or for the non-granted requester, SHALL be ignored.
REQ-023 busy_o SHALL be 1 whenever the state is not IDLE.

Reset
REQ-024 Assertion of rst_n = 0 SHALL take effect immediately and asynchronously at any state, with no clock required, abandoning any in-flight operation with no response.
REQ-025 While in reset:
- State = IDLE.
- All outputs = 0, including rsp_valid_o, req_ready_o, do*, inv_cnt_o and busy_o.
- last granted = requester 1, so requester 0 wins the first contention.
REQ-026 After rst_n deasserts, the first grant SHALL be possible on the next rising edge.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Single EQ: requester 0 sends A = B = 0x3F80 -> doEq_o pulse at T+1; rsp_valid_o = 01, rsp_cmp_o = 1, rsp_inv_o = 0 at T+3.
- Contention: both requesters valid every cycle after reset, rsp_ready_i = 11 -> grants alternate 0,1,0,1; each response completes in 4 cycles.
- NaN handling: LT with A = 0x7F81 (SNaN), B = 0x3F80 -> rsp_cmp_o = 0, rsp_inv_o = 1, inv_cnt_o = 1.
- Illegal op 11 -> no do* pulse; rsp_valid_o at T+1 with rsp_inv_o = 1.
- Backpressure: hold rsp_ready_i = 0 for 5 cycles -> rsp_valid_o and rsp_cmp_o stable, req_ready_o = 0 throughout.
- Mid-operation reset: drop rst_n in WAIT -> all outputs 0 immediately; after release, requester 1 alone is granted.
- Counter saturation: 260 invalid responses -> inv_cnt_o = 0xFF.
